ucsbece154_icache_lru: RTL

Parametrised set-associative instruction cache sitting between the core fetch stage and the SDRAM controller. It is the next generation of the team's icache and adds four behaviours:
- true-LRU replacement
- block-aligned burst refill with early restart (the requested word is forwarded as soon as it arrives)
- a whole-cache flush input
- single-cycle hit throughput

---
 rtl/ucsbece154_icache_lru.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/ucsbece154_icache_lru.sv
// Set-associative instruction cache with true-LRU replacement, block refill with
// early restart of the critical word, whole-cache flush and single-cycle hits.
module ucsbece154_icache_lru #(
  parameter int NUM_SETS    = 8,
  parameter int NUM_WAYS    = 4,
  parameter int BLOCK_WORDS = 4,
  parameter int WORD_SIZE   = 32
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 ReadEnable,
  input  logic [31:0]          ReadAddress,
  input  logic                 Flush,
  output logic [WORD_SIZE-1:0] Instruction,
  output logic                 Ready,
  output logic                 Busy,
  output logic [31:0]          MemReadAddress,
  output logic                 MemReadRequest,
  input  logic [WORD_SIZE-1:0] MemDataIn,
  input  logic                 MemDataReady
);

  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int LSB_W = OFF_W + 2;
  localparam int TAG_W = 32 - LSB_W - IDX_W;

  typedef enum logic {IDLE = 1'b0, REFILL = 1'b1} state_t;
  typedef logic [NUM_WAYS-1:0][WAY_W-1:0] ages_t;

  state_t state_q, state_d;

  logic [NUM_WAYS-1:0]  valid_q [NUM_SETS];
  logic [TAG_W-1:0]     tag_q   [NUM_SETS][NUM_WAYS];
  logic [WORD_SIZE-1:0] data_q  [NUM_SETS][NUM_WAYS][BLOCK_WORDS];
  ages_t                age_q   [NUM_SETS];

  logic [IDX_W-1:0]     idx_l_q;
  logic [TAG_W-1:0]     tag_l_q;
  logic [OFF_W-1:0]     off_l_q;
  logic [WAY_W-1:0]     victim_l_q;
  logic [OFF_W-1:0]     beat_q;
  logic                 flush_pend_q;
  logic [31:0]          mem_addr_q;
  logic [WORD_SIZE-1:0] instr_q, instr_d;
  logic                 ready_q, ready_d;

  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             unused_addr_bits;

  assign req_off          = ReadAddress[LSB_W-1:2];
  assign req_idx          = ReadAddress[LSB_W+IDX_W-1:LSB_W];
  assign req_tag          = ReadAddress[31:LSB_W+IDX_W];
  assign unused_addr_bits = ^ReadAddress[1:0];

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim;
  logic             any_inv;
  logic             accept, do_hit, do_miss;
  logic             beat_ok, last_beat, crit_beat;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Invalid ways only arise from whole-cache clears, so they are filled first.
  always_comb begin
    victim  = '0;
    any_inv = 1'b0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) begin
        victim  = WAY_W'(w);
        any_inv = 1'b1;
      end
    end
    if (!any_inv) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (age_q[req_idx][w] == WAY_W'(NUM_WAYS - 1)) victim = WAY_W'(w);
      end
    end
  end

  assign accept    = (state_q == IDLE) && ReadEnable && !Flush;
  assign do_hit    = accept && hit;
  assign do_miss   = accept && !hit;
  assign beat_ok   = (state_q == REFILL) && MemDataReady;
  assign last_beat = beat_ok && (beat_q == OFF_W'(BLOCK_WORDS - 1));
  assign crit_beat = beat_ok && (beat_q == off_l_q);

  function automatic ages_t lru_touch(input ages_t a, input logic [WAY_W-1:0] u);
    ages_t r;
    r = a;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (WAY_W'(w) == u)   r[w] = '0;
      else if (a[w] < a[u]) r[w] = a[w] + WAY_W'(1);
    end
    return r;
  endfunction

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (do_miss)   state_d = REFILL;
      REFILL:  if (last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_d = 1'b0;
    instr_d = instr_q;
    if (do_hit) begin
      ready_d = 1'b1;
      instr_d = data_q[req_idx][hit_way][req_off];
    end else if (crit_beat) begin
      ready_d = 1'b1;
      instr_d = MemDataIn;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) age_q[s][w] <= WAY_W'(w);
      end
      ready_q      <= 1'b0;
      instr_q      <= '0;
      mem_addr_q   <= '0;
      beat_q       <= '0;
      flush_pend_q <= 1'b0;
      idx_l_q      <= '0;
      tag_l_q      <= '0;
      off_l_q      <= '0;
      victim_l_q   <= '0;
    end else begin
      ready_q <= ready_d;
      instr_q <= instr_d;
      if (state_q == IDLE) begin
        if (Flush) begin
          for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
        end else if (do_hit) begin
          age_q[req_idx] <= lru_touch(age_q[req_idx], hit_way);
        end else if (do_miss) begin
          idx_l_q                  <= req_idx;
          tag_l_q                  <= req_tag;
          off_l_q                  <= req_off;
          victim_l_q               <= victim;
          mem_addr_q               <= {ReadAddress[31:LSB_W], {LSB_W{1'b0}}};
          beat_q                   <= '0;
          flush_pend_q             <= 1'b0;
          valid_q[req_idx][victim] <= 1'b0;
        end
      end else begin
        if (Flush) flush_pend_q <= 1'b1;
        if (beat_ok) begin
          data_q[idx_l_q][victim_l_q][beat_q] <= MemDataIn;
          beat_q                              <= beat_q + OFF_W'(1);
          if (last_beat) begin
            tag_q[idx_l_q][victim_l_q] <= tag_l_q;
            age_q[idx_l_q]             <= lru_touch(age_q[idx_l_q], victim_l_q);
            if (flush_pend_q || Flush) begin
              for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
            end else begin
              valid_q[idx_l_q][victim_l_q] <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign Instruction    = instr_q;
  assign Ready          = ready_q;
  assign Busy           = (state_q == REFILL);
  assign MemReadRequest = (state_q == REFILL);
  assign MemReadAddress = mem_addr_q;

endmodule
